// File: rtl/anim_pkg.sv
// Shared animal/frame codes, FSM state type and small grant helpers for the animation scheduler.
package anim_pkg;

    localparam logic [1:0] ANI_CAT     = 2'b00;
    localparam logic [1:0] ANI_DOG     = 2'b01;
    localparam logic [1:0] ANI_MOUSE   = 2'b10;
    localparam logic [1:0] ANI_NONE    = 2'b11;

    localparam logic [1:0] FRAME_LEFT  = 2'b00;
    localparam logic [1:0] FRAME_RIGHT = 2'b11;

    localparam logic [3:0] MODE_IDLE   = 4'b1100;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, FINISH} anim_state_e;

    // Lowest-index set bit wins; bit 0 is the highest priority.
    function automatic logic [2:0] pick_low(input logic [2:0] r);
        logic [2:0] g;
        g = 3'b000;
        if (r[0])      g = 3'b001;
        else if (r[1]) g = 3'b010;
        else if (r[2]) g = 3'b100;
        return g;
    endfunction

    function automatic logic [1:0] onehot_to_ani(input logic [2:0] g);
        logic [1:0] a;
        a = ANI_NONE;
        if (g[0])      a = ANI_CAT;
        else if (g[1]) a = ANI_DOG;
        else if (g[2]) a = ANI_MOUSE;
        return a;
    endfunction

endpackage

// File: rtl/anim_rr_arb.sv
// Three-way one-hot arbiter {mouse, dog, cat}. ANIM_RR_EN selects round-robin with a
// last-grant pointer; otherwise fixed priority cat > dog > mouse.
module anim_rr_arb
    import anim_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [2:0] req_i,
    output logic [2:0] gnt_o
);

`ifdef ANIM_RR_EN
    logic [1:0] ptr_q, ptr_d;
    logic [2:0] pick;

    // Rotate so the animal after the last grant sits at bit 0, pick, rotate back.
    always_comb begin
        pick  = 3'b000;
        gnt_o = 3'b000;
        ptr_d = ptr_q;
        case (ptr_q)
            ANI_CAT: begin
                pick  = pick_low({req_i[0], req_i[2], req_i[1]});
                gnt_o = {pick[1], pick[0], pick[2]};
            end
            ANI_DOG: begin
                pick  = pick_low({req_i[1], req_i[0], req_i[2]});
                gnt_o = {pick[0], pick[2], pick[1]};
            end
            default: begin
                pick  = pick_low(req_i);
                gnt_o = pick;
            end
        endcase
        if (!en_i) gnt_o = 3'b000;
        if (|gnt_o) ptr_d = onehot_to_ani(gnt_o);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ptr_q <= ANI_MOUSE;
        else         ptr_q <= ptr_d;
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign gnt_o = en_i ? pick_low(req_i) : 3'b000;
`endif

endmodule

// File: rtl/anim_scheduler.sv
// Shares the dot-matrix animation channel between cat, dog and mouse, playing one
// four-frame move per grant. Define ANIM_RR_EN for round-robin arbitration.
module anim_scheduler #(
    parameter int FRAME_TICKS = 1000,
    parameter int CNT_W       = 10
) (
    input  logic       clk1khz,
    input  logic       rst,
    input  logic       cat,
    input  logic       dog,
    input  logic       mouse,
    input  logic       off,
    output logic [3:0] mode,
    output logic       busy,
    output logic       done,
    output logic [2:0] side,
    output logic [2:0] pending
);
    import anim_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 1);

    anim_state_e      state_q, state_d;
    logic [2:0]       req_q, rise;
    logic [2:0]       pending_q, pending_d;
    logic [2:0]       side_q, side_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [3:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       arb_gnt;
    logic             arb_en;
    logic             dir_right;
    logic [1:0]       target;

    assign rise   = {mouse, dog, cat} & ~req_q;
    assign arb_en = (state_q == IDLE) && !off;

    anim_rr_arb u_arb (
        .clk_i  (clk1khz),
        .rst_ni (rst),
        .en_i   (arb_en),
        .req_i  (pending_q),
        .gnt_o  (arb_gnt)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        side_d    = side_q;
        gnt_d     = gnt_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        // An animal on the left walks right toward frame 3, and vice versa.
        dir_right = ~|(side_q & gnt_q);
        target    = dir_right ? FRAME_RIGHT : FRAME_LEFT;

        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    gnt_d     = arb_gnt;
                    pending_d = pending_q & ~arb_gnt;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                mode_d  = {onehot_to_ani(gnt_q), dir_right ? FRAME_LEFT : FRAME_RIGHT};
                cnt_d   = '0;
                state_d = PLAY;
            end
            PLAY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (mode_q[1:0] == target) begin
                        state_d = FINISH;
                    end else if (dir_right) begin
                        mode_d = {mode_q[3:2], mode_q[1:0] + 2'd1};
                    end else begin
                        mode_d = {mode_q[3:2], mode_q[1:0] - 2'd1};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FINISH: begin
                side_d  = side_q ^ gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // New edges win over the grant clear, so a re-press during its own grant survives.
        pending_d = pending_d | rise;

        if (off) begin
            state_d   = IDLE;
            pending_d = 3'b000;
            mode_d    = MODE_IDLE;
            cnt_d     = '0;
            side_d    = side_q;
        end
    end

    always_ff @(posedge clk1khz or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            req_q     <= 3'b000;
            pending_q <= 3'b000;
            side_q    <= 3'b000;
            gnt_q     <= 3'b000;
            mode_q    <= MODE_IDLE;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= {mouse, dog, cat};
            pending_q <= pending_d;
            side_q    <= side_d;
            gnt_q     <= gnt_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
        end
    end

    assign mode    = mode_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FINISH);
    assign side    = side_q;
    assign pending = pending_q;

endmodule
